// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: types shared by the multicore memory system.
//   ramstate_t  : RAM handshake state (FREE, BUSY, ACCESS, ERROR)
//   word_t      : 32-bit memory word
//   arb_state_t : mem_arbiter FSM state (IDLE, GRANT)
//   req_id_w()  : requester ID width for a given core count
//                 (2*CPUS requesters: dcaches 0..CPUS-1, icaches CPUS..2*CPUS-1)
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Width needed to hold any requester ID (dcache and icache of every CPU).
  function automatic int req_id_w(input int cpus);
    return (2 * cpus > 2) ? $clog2(2 * cpus) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selection.
//   req   in  N      request vector
//   ptr   in  PTR_W  index with highest priority this round
//   gnt   out N      one-hot grant (lowest requesting index at or after ptr, wrapping)
//   valid out 1      at least one request present
module rr_picker #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  logic hit_s;

  // Two passes: indices at/after ptr first, then the wrapped-around ones.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    hit_s = 1'b0;
    for (int j = 0; j < N; j++) begin
      hit_s  = req[j] && !valid && (j >= int'(ptr));
      gnt[j] = hit_s;
      valid  = valid | hit_s;
    end
    for (int j = 0; j < N; j++) begin
      hit_s  = req[j] && !valid && (j < int'(ptr));
      gnt[j] = gnt[j] | hit_s;
      valid  = valid | hit_s;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the icache and dcache of every CPU.
// dcache requests beat icache requests; within a class, round-robin from rr_q.
// An owner keeps the port for up to BURST_MAX completed words.
// Ports:
//   CLK, nRST                      clock, async active-low reset
//   iREN/iaddr -> iwait/iload      icache requesters (per CPU)
//   dREN/dWEN/daddr/dstore ->
//     dwait/dload                  dcache requesters (per CPU)
//   ramREN/ramWEN/ramaddr/ramstore RAM command, ramload/ramstate RAM response
//   ccinv/ccaddr                   snoop invalidate (only with SNOOP_INV_EN)
// Optional feature macro: SNOOP_INV_EN.
module mem_arbiter #(
  parameter int CPUS      = 2,
  parameter int BURST_MAX = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [CPUS-1:0]    iREN,
  input  logic [CPUS*32-1:0] iaddr,
  output logic [CPUS-1:0]    iwait,
  output logic [CPUS*32-1:0] iload,
  input  logic [CPUS-1:0]    dREN,
  input  logic [CPUS-1:0]    dWEN,
  input  logic [CPUS*32-1:0] daddr,
  input  logic [CPUS*32-1:0] dstore,
  output logic [CPUS-1:0]    dwait,
  output logic [CPUS*32-1:0] dload,
  output logic               ramREN,
  output logic               ramWEN,
  output logic [31:0]        ramaddr,
  output logic [31:0]        ramstore,
  input  logic [31:0]        ramload,
  input  logic [1:0]         ramstate,
  output logic [CPUS-1:0]    ccinv,
  output logic [CPUS*32-1:0] ccaddr
);
  import cpu_types_pkg::*;

  localparam int ID_W  = req_id_w(CPUS);
  localparam int CPU_W = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [CPU_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  word_t iaddr_a [CPUS];
  word_t daddr_a [CPUS];
  word_t dstore_a[CPUS];

  logic [CPUS-1:0]  dreq_s, dgnt_s, igrant_s;
  logic             dvalid_s, ivalid_s;
  logic [CPU_W-1:0] d_idx_s, i_idx_s, owner_cpu_s, rr_next_s;
  logic             owner_is_d_s;
  logic             own_req_s, own_ren_s, own_wen_s;
  word_t            own_addr_s, own_store_s;
  logic             active_s, word_done_s, last_word_s;

  for (genvar g = 0; g < CPUS; g++) begin : g_unpack
    assign iaddr_a[g]  = iaddr[g*32 +: 32];
    assign daddr_a[g]  = daddr[g*32 +: 32];
    assign dstore_a[g] = dstore[g*32 +: 32];
  end

  assign dreq_s = dREN | dWEN;
  assign iload  = {CPUS{ramload}};
  assign dload  = {CPUS{ramload}};

  rr_picker #(.N(CPUS), .PTR_W(CPU_W)) u_dpick (
    .req(dreq_s), .ptr(rr_q), .gnt(dgnt_s), .valid(dvalid_s)
  );

  rr_picker #(.N(CPUS), .PTR_W(CPU_W)) u_ipick (
    .req(iREN), .ptr(rr_q), .gnt(igrant_s), .valid(ivalid_s)
  );

  // One-hot grants to CPU indices.
  always_comb begin
    d_idx_s = CPU_W'(0);
    i_idx_s = CPU_W'(0);
    for (int c = 0; c < CPUS; c++) begin
      d_idx_s = dgnt_s[c]   ? CPU_W'(c) : d_idx_s;
      i_idx_s = igrant_s[c] ? CPU_W'(c) : i_idx_s;
    end
  end

  // Decode the owner ID and select its request signals.
  always_comb begin
    owner_is_d_s = (owner_q < ID_W'(CPUS));
    owner_cpu_s  = owner_is_d_s ? CPU_W'(owner_q) : CPU_W'(owner_q - ID_W'(CPUS));
    if (owner_is_d_s) begin
      own_req_s   = dREN[owner_cpu_s] | dWEN[owner_cpu_s];
      own_wen_s   = dWEN[owner_cpu_s];
      own_ren_s   = dREN[owner_cpu_s] & ~dWEN[owner_cpu_s];
      own_addr_s  = daddr_a[owner_cpu_s];
      own_store_s = dstore_a[owner_cpu_s];
    end else begin
      own_req_s   = iREN[owner_cpu_s];
      own_wen_s   = 1'b0;
      own_ren_s   = iREN[owner_cpu_s];
      own_addr_s  = iaddr_a[owner_cpu_s];
      own_store_s = 32'h0000_0000;
    end
    // A dropped request abandons the access, so nothing is driven or completed.
    active_s    = (state_q == GRANT) && own_req_s;
    // ERROR is not ACCESS, so it simply stalls and the access is retried.
    word_done_s = active_s && (ramstate_t'(ramstate) == ACCESS);
    last_word_s = (cnt_q == CNT_W'(BURST_MAX - 1));
    rr_next_s   = (owner_cpu_s == CPU_W'(CPUS - 1)) ? CPU_W'(0) : owner_cpu_s + CPU_W'(1);
  end

  // Next-state logic: arbitration in IDLE, burst tracking in GRANT.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (dvalid_s) begin
          owner_d = ID_W'(d_idx_s);
          cnt_d   = CNT_W'(0);
          state_d = GRANT;
        end else if (ivalid_s) begin
          owner_d = ID_W'(CPUS) + ID_W'(i_idx_s);
          cnt_d   = CNT_W'(0);
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!own_req_s) begin
          state_d = IDLE;
          rr_d    = rr_next_s;
        end else if (word_done_s && last_word_s) begin
          state_d = IDLE;
          rr_d    = rr_next_s;
          cnt_d   = CNT_W'(0);
        end else if (word_done_s) begin
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = GRANT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      owner_q <= ID_W'(0);
      rr_q    <= CPU_W'(0);
      cnt_q   <= CNT_W'(0);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM command and per-requester wait from the current owner.
  always_comb begin
    ramREN   = active_s & own_ren_s;
    ramWEN   = active_s & own_wen_s;
    ramaddr  = active_s ? own_addr_s : 32'h0000_0000;
    ramstore = (active_s && own_wen_s) ? own_store_s : 32'h0000_0000;
    for (int c = 0; c < CPUS; c++) begin
      dwait[c] = ~(word_done_s &  owner_is_d_s & (owner_cpu_s == CPU_W'(c)));
      iwait[c] = ~(word_done_s & ~owner_is_d_s & (owner_cpu_s == CPU_W'(c)));
    end
  end

`ifdef SNOOP_INV_EN
  logic             snoop_vld_q, snoop_vld_d;
  logic [CPU_W-1:0] snoop_cpu_q, snoop_cpu_d;
  word_t            snoop_addr_q, snoop_addr_d;

  // Capture each completed dcache write for a one-cycle invalidate broadcast.
  always_comb begin
    snoop_vld_d  = word_done_s & owner_is_d_s & own_wen_s;
    snoop_cpu_d  = owner_cpu_s;
    snoop_addr_d = own_addr_s;
  end

  // Snoop registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      snoop_vld_q  <= 1'b0;
      snoop_cpu_q  <= CPU_W'(0);
      snoop_addr_q <= 32'h0000_0000;
    end else begin
      snoop_vld_q  <= snoop_vld_d;
      snoop_cpu_q  <= snoop_cpu_d;
      snoop_addr_q <= snoop_addr_d;
    end
  end

  // Invalidate every CPU except the writer.
  always_comb begin
    for (int c = 0; c < CPUS; c++) begin
      ccinv[c]          = snoop_vld_q && (snoop_cpu_q != CPU_W'(c));
      ccaddr[c*32 +: 32] = ccinv[c] ? snoop_addr_q : 32'h0000_0000;
    end
  end
`else
  assign ccinv  = '0;
  assign ccaddr = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int CPUS = 2;
  localparam logic [31:0] D1A = 32'h0000_0500;
  localparam logic [31:0] I0A = 32'h0000_0800;
  localparam logic [31:0] I1A = 32'h0000_0C00;
  localparam logic [31:0] DS0 = 32'h1234_5678;
  localparam logic [31:0] DS1 = 32'h9ABC_DEF0;
  localparam logic [31:0] RLD = 32'hDEAD_BEEF;
  localparam logic [1:0]  RF = 2'd0, RB = 2'd1, RA = 2'd2, RE = 2'd3;
`ifdef SNOOP_INV_EN
  localparam logic [1:0] SN = 2'b10;
`else
  localparam logic [1:0] SN = 2'b00;
`endif

  logic               CLK = 1'b0;
  logic               nRST;
  logic [CPUS-1:0]    iREN, iwait, dREN, dWEN, dwait, ccinv;
  logic [CPUS*32-1:0] iaddr, iload, daddr, dstore, dload, ccaddr;
  logic               ramREN, ramWEN;
  logic [31:0]        ramaddr, ramstore, ramload;
  logic [1:0]         ramstate;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.CPUS(CPUS), .BURST_MAX(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .ccinv(ccinv), .ccaddr(ccaddr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  ir, dr, dw;
    logic [31:0] a0;
    logic [1:0]  rs;
    logic        ren, wen;
    logic [31:0] addr;
    logic [1:0]  iw, dwt, cc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] ir, input logic [1:0] dr, input logic [1:0] dw,
                              input logic [31:0] a0, input logic [1:0] rs, input logic ren,
                              input logic wen, input logic [31:0] addr, input logic [1:0] iw,
                              input logic [1:0] dwt, input logic [1:0] cc);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.a0 = a0; v.rs = rs; v.ren = ren; v.wen = wen;
    v.addr = addr; v.iw = iw; v.dwt = dwt; v.cc = cc;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row%0d %s actual=%h expected=%h", row, name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ir, input logic [1:0] dr, input logic [1:0] dw,
                       input logic [31:0] a0, input logic [1:0] rs);
    iREN = ir; dREN = dr; dWEN = dw; ramstate = rs;
    daddr = {D1A, a0};
  endtask

  initial begin
    nRST = 1'b0;
    iaddr = {I1A, I0A};
    dstore = {DS1, DS0};
    ramload = RLD;
    drive(2'b00, 2'b00, 2'b00, 32'h0, RF);

    // Vectors: one row per cycle, outputs expected during that cycle.
    // Single read, ERROR/BUSY retried, ACCESS on later GRANT cycle.
    vecs.push_back(mk(2'b00, 2'b01, 2'b00, 32'h100, RF, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(2'b00, 2'b01, 2'b00, 32'h100, RE, 1'b1, 1'b0, 32'h100, 2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(2'b00, 2'b01, 2'b00, 32'h100, RB, 1'b1, 1'b0, 32'h100, 2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(2'b00, 2'b01, 2'b00, 32'h100, RA, 1'b1, 1'b0, 32'h100, 2'b11, 2'b10, 2'b00));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 32'h100, RF, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 32'h100, RF, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, 2'b00));
    // Two-word burst 0x200/0x204, then rr=1 lets dcache 1 win a tie.
    vecs.push_back(mk(2'b00, 2'b01, 2'b00, 32'h200, RF, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(2'b00, 2'b01, 2'b00, 32'h200, RA, 1'b1, 1'b0, 32'h200, 2'b11, 2'b10, 2'b00));
    vecs.push_back(mk(2'b00, 2'b01, 2'b00, 32'h204, RA, 1'b1, 1'b0, 32'h204, 2'b11, 2'b10, 2'b00));
    vecs.push_back(mk(2'b00, 2'b11, 2'b00, 32'h200, RF, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(2'b00, 2'b11, 2'b00, 32'h200, RA, 1'b1, 1'b0, D1A,     2'b11, 2'b01, 2'b00));
    // Owner drops mid-burst with ACCESS present: no strobe, no wait pulse.
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 32'h200, RA, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, 2'b00));
    // icache 0 and dcache 1 together: dcache first, icache on next IDLE.
    vecs.push_back(mk(2'b01, 2'b10, 2'b00, 32'h100, RF, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(2'b01, 2'b10, 2'b00, 32'h100, RA, 1'b1, 1'b0, D1A,     2'b11, 2'b01, 2'b00));
    vecs.push_back(mk(2'b01, 2'b10, 2'b00, 32'h100, RA, 1'b1, 1'b0, D1A,     2'b11, 2'b01, 2'b00));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 32'h100, RF, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 32'h100, RA, 1'b1, 1'b0, I0A,     2'b10, 2'b11, 2'b00));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 32'h100, RF, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, 2'b00));
    // Both dcaches held: alternating two-word bursts (rr starts at 1).
    vecs.push_back(mk(2'b00, 2'b11, 2'b00, 32'h100, RF, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(2'b00, 2'b11, 2'b00, 32'h100, RA, 1'b1, 1'b0, D1A,     2'b11, 2'b01, 2'b00));
    vecs.push_back(mk(2'b00, 2'b11, 2'b00, 32'h100, RA, 1'b1, 1'b0, D1A,     2'b11, 2'b01, 2'b00));
    vecs.push_back(mk(2'b00, 2'b11, 2'b00, 32'h100, RA, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(2'b00, 2'b11, 2'b00, 32'h100, RA, 1'b1, 1'b0, 32'h100, 2'b11, 2'b10, 2'b00));
    vecs.push_back(mk(2'b00, 2'b11, 2'b00, 32'h100, RA, 1'b1, 1'b0, 32'h100, 2'b11, 2'b10, 2'b00));
    vecs.push_back(mk(2'b00, 2'b11, 2'b00, 32'h100, RA, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(2'b00, 2'b11, 2'b00, 32'h100, RA, 1'b1, 1'b0, D1A,     2'b11, 2'b01, 2'b00));
    vecs.push_back(mk(2'b00, 2'b11, 2'b00, 32'h100, RA, 1'b1, 1'b0, D1A,     2'b11, 2'b01, 2'b00));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 32'h100, RF, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, 2'b00));
    // dcache 0 write to 0x300; snoop invalidate (if built) the cycle after.
    vecs.push_back(mk(2'b00, 2'b00, 2'b01, 32'h300, RF, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(2'b00, 2'b00, 2'b01, 32'h300, RA, 1'b0, 1'b1, 32'h300, 2'b11, 2'b10, 2'b00));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 32'h300, RF, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, SN));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 32'h300, RF, 1'b0, 1'b0, 32'h0,   2'b11, 2'b11, 2'b00));

    // Reset state.
    @(negedge CLK); #1;
    chk("rst_ramREN", -1, {31'b0, ramREN}, 32'h0);
    chk("rst_ramWEN", -1, {31'b0, ramWEN}, 32'h0);
    chk("rst_ramaddr", -1, ramaddr, 32'h0);
    chk("rst_ramstore", -1, ramstore, 32'h0);
    chk("rst_waits", -1, {28'b0, iwait, dwait}, 32'hF);
    chk("rst_ccinv", -1, {30'b0, ccinv}, 32'h0);

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge CLK);
      nRST = 1'b1;
      drive(vecs[r].ir, vecs[r].dr, vecs[r].dw, vecs[r].a0, vecs[r].rs);
      #1;
      chk("ramREN", r, {31'b0, ramREN}, {31'b0, vecs[r].ren});
      chk("ramWEN", r, {31'b0, ramWEN}, {31'b0, vecs[r].wen});
      chk("ramaddr", r, ramaddr, vecs[r].addr);
      chk("ramstore", r, ramstore, vecs[r].wen ? DS0 : 32'h0);
      chk("iwait", r, {30'b0, iwait}, {30'b0, vecs[r].iw});
      chk("dwait", r, {30'b0, dwait}, {30'b0, vecs[r].dwt});
      chk("ccinv", r, {30'b0, ccinv}, {30'b0, vecs[r].cc});
      for (int c = 0; c < CPUS; c++) begin
        chk("ccaddr", r, ccaddr[c*32 +: 32], vecs[r].cc[c] ? 32'h300 : 32'h0);
        if (!vecs[r].dwt[c]) chk("dload", r, dload[c*32 +: 32], RLD);
        if (!vecs[r].iw[c])  chk("iload", r, iload[c*32 +: 32], RLD);
      end
    end

    // Reset mid-write (rr is 1 here), then confirm rr returns to 0.
    @(negedge CLK);
    drive(2'b00, 2'b00, 2'b01, 32'h300, RB);
    @(negedge CLK); #1;
    chk("pre_rst_ramWEN", 100, {31'b0, ramWEN}, 32'h1);
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst_ramWEN", 101, {31'b0, ramWEN}, 32'h0);
    chk("mid_rst_ramaddr", 101, ramaddr, 32'h0);
    chk("mid_rst_waits", 101, {28'b0, iwait, dwait}, 32'hF);
    drive(2'b00, 2'b00, 2'b00, 32'h100, RB);
    @(negedge CLK);
    nRST = 1'b1;
    drive(2'b00, 2'b11, 2'b00, 32'h100, RB);
    #1;
    chk("post_rst_idle_ramREN", 102, {31'b0, ramREN}, 32'h0);
    @(negedge CLK); #1;
    chk("post_rst_ramREN", 103, {31'b0, ramREN}, 32'h1);
    chk("post_rst_rr0_addr", 103, ramaddr, 32'h100);
    chk("post_rst_dwait", 103, {30'b0, dwait}, 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
